// File: rtl/mpc_pkg.sv
// Shared constants and types for the program sequencer.
// MPC_SEQ_STEP_EN (optional) adds single-step control to mpc_seq.
package mpc_pkg;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned RES_W   = 9;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StDone
  } mpc_seq_state_t;

endpackage

// File: rtl/mpc_seq_imem.sv
// Program memory: one write port, synchronous registered read.
// Contents are never reset; only the read register is cleared.
module mpc_seq_imem
  import mpc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // The read register doubles as the issued instruction, so it holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mpc_seq.sv
// Program sequencer feeding the ALU stage; captures each result one cycle after issue.
// Define MPC_SEQ_STEP_EN to add a 'step' input that gates every fetch.
module mpc_seq
  import mpc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_en,
  input  logic [AW-1:0]      ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               start,
`ifdef MPC_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic [AW:0]        len,
  output logic [INSTR_W-1:0] instr_o,
  input  logic [RES_W-1:0]   alu_i,
  output logic [RES_W-1:0]   res_o,
  output logic [AW-1:0]      res_idx,
  output logic               res_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneLen   = (AW+1)'(1);

  mpc_seq_state_t   state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW:0]      len_q, len_d;
  logic [RES_W-1:0] res_q;
  logic [AW-1:0]    idx_q;
  logic             valid_q, done_q;
  logic             step_ok, fetch, last;

`ifdef MPC_SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign last = ({1'b0, pc_q} == (len_q - OneLen));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    fetch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            state_d = StDone;
          end else begin
            len_d   = (len > DepthLen) ? DepthLen : len;
            pc_d    = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (step_ok) begin
          fetch   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (last) begin
          state_d = StDone;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      valid_q <= (state_q == StExec);
      done_q  <= (state_q == StDone);
      if (state_q == StExec) begin
        res_q <= alu_i;
        idx_q <= pc_q;
      end
    end
  end

  // Writes only land while idle, so a same-cycle start sees the new word.
  mpc_seq_imem #(
    .DEPTH (DEPTH)
  ) u_imem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ld_en && (state_q == StIdle)),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (fetch),
    .raddr_i (pc_q),
    .rdata_o (instr_o)
  );

  assign res_o     = res_q;
  assign res_idx   = idx_q;
  assign res_valid = valid_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mpc_seq.sv
// Self-checking bench for mpc_seq: directed programs plus random programs
// checked against a program-level reference model.
module tb_mpc_seq;
  import mpc_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst, ld_en, start;
  logic [AW-1:0]      ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic [AW:0]        len;
  logic [INSTR_W-1:0] instr_o;
  logic [RES_W-1:0]   alu_i, res_o;
  logic [AW-1:0]      res_idx;
  logic               res_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [INSTR_W-1:0] mem_m [DEPTH];
  logic [RES_W-1:0]   res_log [$];

  always #5 clk = ~clk;

  // Behavioural ALU: 9-bit result of the 8-bit operands.
  function automatic logic [RES_W-1:0] alu_ref(input logic [INSTR_W-1:0] w);
    int a, b, r;
    a = int'(w[7:0]);
    b = int'(w[15:8]);
    case (w[17:16])
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_INC:  r = a + 1;
      default: r = a - 1;
    endcase
    return RES_W'(r & 32'h1FF);
  endfunction

  assign alu_i = alu_ref(instr_o);

  mpc_seq #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .len       (len),
    .instr_o   (instr_o),
    .alu_i     (alu_i),
    .res_o     (res_o),
    .res_idx   (res_idx),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [INSTR_W-1:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    mem_m[a] = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Start a run of l instructions and check every cycle against the model.
  // contend: fire ld_en/start mid-run; with_ld: load word (la, ld) on the start cycle.
  task automatic run(input int l, input string tag, input bit contend,
                     input bit with_ld, input int la, input logic [INSTR_W-1:0] ldw);
    int n, got, dones;
    n = (l > DEPTH) ? DEPTH : l;
    got = 0;
    dones = 0;
    res_log.delete();
    if (with_ld) begin
      ld_en    = 1'b1;
      ld_addr  = AW'(la);
      ld_data  = ldw;
      mem_m[la] = ldw;
    end
    start = 1'b1;
    len   = (AW+1)'(l);
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 2 * n + 3; c++) begin
      tick();
      chk({tag, "_valid"}, 32'(res_valid), 32'((c % 2 == 0) && c >= 2 && c <= 2 * n));
      chk({tag, "_done"}, 32'(done), 32'(c == 2 * n + 1));
      chk({tag, "_busy"}, 32'(busy), 32'(c < 2 * n + 1));
      if ((c % 2 == 1) && c <= 2 * n - 1)
        chk({tag, "_instr"}, 32'(instr_o), 32'(mem_m[(c - 1) / 2]));
      if (res_valid) begin
        if (got < n) begin
          chk({tag, "_res"}, 32'(res_o), 32'(alu_ref(mem_m[got])));
          chk({tag, "_idx"}, 32'(res_idx), 32'(got));
        end
        res_log.push_back(res_o);
        got++;
      end
      if (done) dones++;
      if (contend && c == 2) begin
        ld_en   = 1'b1;
        ld_addr = AW'(1);
        ld_data = ~mem_m[1];
        start   = 1'b1;
        len     = (AW+1)'(1);
      end else begin
        ld_en = 1'b0;
        start = 1'b0;
      end
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
    chk({tag, "_ndone"}, 32'(dones), 32'd1);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; start = 1'b0; ld_addr = '0; ld_data = '0; len = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_instr", 32'(instr_o), 32'd0);
    chk("rst_res", 32'(res_o), 32'd0);
    chk("rst_idx", 32'(res_idx), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Single ADD instruction.
    load(0, 18'h00503);
    run(1, "t1", 1'b0, 1'b0, 0, '0);
    chk("t1_const_res", 32'(res_log.size() > 0 ? res_log[0] : 9'h0), 32'h008);

    // One of each remaining opcode.
    load(0, 18'h10503);
    load(1, 18'h200FF);
    load(2, 18'h30000);
    run(3, "t2", 1'b0, 1'b0, 0, '0);
    chk("t2_n", 32'(res_log.size()), 32'd3);
    if (res_log.size() == 3) begin
      chk("t2_r0", 32'(res_log[0]), 32'h1FE);
      chk("t2_r1", 32'(res_log[1]), 32'h100);
      chk("t2_r2", 32'(res_log[2]), 32'h1FF);
    end
    chk("t2_hold_idx", 32'(res_idx), 32'd2);

    // Zero-length run.
    run(0, "t3", 1'b0, 1'b0, 0, '0);

    // Random program, over-long length clamps to DEPTH.
    for (int i = 0; i < DEPTH; i++) load(i, INSTR_W'($urandom));
    run(DEPTH + 5, "t4", 1'b0, 1'b0, 0, '0);

    // Mid-run load/start ignored, then rerun shows memory unchanged.
    run(3, "t5", 1'b1, 1'b0, 0, '0);
    run(3, "t5b", 1'b0, 1'b0, 0, '0);

    // Load and start together: new word is executed.
    run(1, "t6", 1'b0, 1'b1, 0, INSTR_W'($urandom));

    // Random lengths on random programs.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) load(i, INSTR_W'($urandom));
      run(int'($urandom_range(1, 2 * DEPTH - 1)), "t7", 1'b0, 1'b0, 0, '0);
    end

    // Reset during EXEC of instruction 1 of 3.
    load(0, 18'h10503);
    load(1, 18'h200FF);
    load(2, 18'h30000);
    start = 1'b1;
    len   = (AW+1)'(3);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("t8_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t8_instr", 32'(instr_o), 32'd0);
    chk("t8_res", 32'(res_o), 32'd0);
    chk("t8_idx", 32'(res_idx), 32'd0);
    chk("t8_valid", 32'(res_valid), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_done", 32'(done), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t8_nodone", 32'(done | res_valid | busy), 32'd0);
    end
    run(3, "t9", 1'b0, 1'b0, 0, '0);
    if (res_log.size() == 3) begin
      chk("t9_r0", 32'(res_log[0]), 32'h1FE);
      chk("t9_r2", 32'(res_log[2]), 32'h1FF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
